// File: rtl/piso_tx_ctrl.sv
// Serial transmit sequencer for a WIDTH-bit PISO register: accept, load, paced shift, framing.
// Optional parity bit after the data bits when PISO_TX_PARITY_EN is defined.
module piso_tx_ctrl #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] piso_d,
  output logic             piso_load,
  output logic             piso_shift,
  output logic             piso_din,
  input  logic             piso_qout,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("piso_tx_ctrl: WIDTH must be >= 1");
  end
  if (BIT_CYCLES < 1) begin : g_bad_bit_cycles
    $error("piso_tx_ctrl: BIT_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 0) begin : g_bad_gap_cycles
    $error("piso_tx_ctrl: GAP_CYCLES must be >= 0");
  end

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PAR, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] cyc_cnt, cyc_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic          last_cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      piso_d  <= '0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      bit_cnt <= bit_nxt;
      gap_cnt <= gap_nxt;
      if (state == IDLE && tx_valid)
        piso_d <= tx_data;
    end
  end

  assign last_cyc = (cyc_cnt == CW'(BIT_CYCLES - 1));

  always_comb begin
    state_nxt  = state;
    cyc_nxt    = cyc_cnt;
    bit_nxt    = bit_cnt;
    gap_nxt    = gap_cnt;
    tx_ready   = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    ser_frame  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) state_nxt = LOAD;
      end
      LOAD: begin
        piso_load = 1'b1;
        cyc_nxt   = '0;
        bit_nxt   = '0;
        gap_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_frame = 1'b1;
        if (!last_cyc) begin
          cyc_nxt = cyc_cnt + CW'(1);
        end else begin
          cyc_nxt = '0;
          if (bit_cnt != BW'(WIDTH - 1)) begin
            piso_shift = 1'b1;
            bit_nxt    = bit_cnt + BW'(1);
          end else begin
`ifdef PISO_TX_PARITY_EN
            state_nxt = PAR;
`else
            if (GAP_CYCLES == 0) begin
              done      = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = GAP;
            end
`endif
          end
        end
      end
`ifdef PISO_TX_PARITY_EN
      PAR: begin
        ser_frame = 1'b1;
        if (!last_cyc) begin
          cyc_nxt = cyc_cnt + CW'(1);
        end else begin
          cyc_nxt = '0;
          // With no gap configured the parity bit closes the frame itself.
          if (GAP_CYCLES == 0) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
          end
        end
      end
`endif
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          done      = 1'b1;
          gap_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign piso_din = 1'b0;

`ifdef PISO_TX_PARITY_EN
  assign ser_out = ser_frame & ((state == PAR) ? ^piso_d : piso_qout);
`else
  assign ser_out = ser_frame & piso_qout;
`endif

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench: three controller instances (BIT_CYCLES/GAP_CYCLES variants) each driving a PISO model.
module tb_piso_tx_ctrl;

`ifdef PISO_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [3:0] tx_data[3];
  logic       tx_valid[3];
  logic       tx_ready[3];
  logic [3:0] piso_d[3];
  logic       piso_load[3], piso_shift[3], piso_din[3], piso_qout[3];
  logic       ser_out[3], ser_frame[3], busy[3], done[3];
  logic [3:0] sr[3];

  int checks = 0;
  int failures = 0;

  // PISO register model: MSB first, zero fill.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) sr[k] <= 4'b0;
      else if (piso_load[k]) sr[k] <= piso_d[k];
      else if (piso_shift[k]) sr[k] <= {sr[k][2:0], piso_din[k]};
    end
  end
  assign piso_qout[0] = sr[0][3];
  assign piso_qout[1] = sr[1][3];
  assign piso_qout[2] = sr[2][3];

  piso_tx_ctrl #(.WIDTH(4), .BIT_CYCLES(1), .GAP_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .piso_d(piso_d[0]), .piso_load(piso_load[0]),
    .piso_shift(piso_shift[0]), .piso_din(piso_din[0]), .piso_qout(piso_qout[0]),
    .ser_out(ser_out[0]), .ser_frame(ser_frame[0]), .busy(busy[0]), .done(done[0]));

  piso_tx_ctrl #(.WIDTH(4), .BIT_CYCLES(3), .GAP_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .piso_d(piso_d[1]), .piso_load(piso_load[1]),
    .piso_shift(piso_shift[1]), .piso_din(piso_din[1]), .piso_qout(piso_qout[1]),
    .ser_out(ser_out[1]), .ser_frame(ser_frame[1]), .busy(busy[1]), .done(done[1]));

  piso_tx_ctrl #(.WIDTH(4), .BIT_CYCLES(1), .GAP_CYCLES(0)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .piso_d(piso_d[2]), .piso_load(piso_load[2]),
    .piso_shift(piso_shift[2]), .piso_din(piso_din[2]), .piso_qout(piso_qout[2]),
    .ser_out(ser_out[2]), .ser_frame(ser_frame[2]), .busy(busy[2]), .done(done[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int k);
    chk({tag, "_ready"}, tx_ready[k], 1);
    chk({tag, "_busy"}, busy[k], 0);
    chk({tag, "_d"}, piso_d[k], 0);
    chk({tag, "_load"}, piso_load[k], 0);
    chk({tag, "_shift"}, piso_shift[k], 0);
    chk({tag, "_din"}, piso_din[k], 0);
    chk({tag, "_ser"}, ser_out[k], 0);
    chk({tag, "_frame"}, ser_frame[k], 0);
    chk({tag, "_done"}, done[k], 0);
  endtask

  // Called at a negedge with instance k idle; returns at the negedge of the LOAD cycle.
  task automatic send(input int k, input logic [3:0] w);
    tx_data[k]  = w;
    tx_valid[k] = 1'b1;
    @(negedge clk);
    tx_valid[k] = 1'b0;
    chk("load", piso_load[k], 1);
    chk("load_d", piso_d[k], w);
    chk("load_rdy", tx_ready[k], 0);
    chk("load_frame", ser_frame[k], 0);
  endtask

  // Walks every frame cycle (data bits, then parity if enabled); ends at the last frame cycle.
  task automatic frame(input int k, input logic [3:0] w, input int bc, output int shifts);
    logic [3:0] wv;
    int b;
    wv = w;
    shifts = 0;
    for (int i = 0; i < (4 + PB) * bc; i++) begin
      @(negedge clk);
      b = i / bc;
      chk("frame_hi", ser_frame[k], 1);
      chk("frame_busy", busy[k], 1);
      chk("ser_bit", ser_out[k], (b < 4) ? wv[3 - b] : ^wv);
      if (b < 4) chk("ser_pass", ser_out[k], piso_qout[k]);
      if (piso_shift[k]) begin
        shifts++;
        chk("shift_pos", i % bc, bc - 1);
      end
    end
  endtask

  int sh, t, t1, t2;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tx_valid[k] = 1'b0;
      tx_data[k]  = 4'b0;
    end
    @(negedge clk);
    chk_idle("rst0", 0);
    chk_idle("rst1", 1);
    chk_idle("rst2", 2);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word, 1 cycle per bit, 1 gap cycle.
    send(0, 4'b1010);
    frame(0, 4'b1010, 1, sh);
    chk("w1_shifts", sh, 3);
    @(negedge clk);
    chk("w1_gap_frame", ser_frame[0], 0);
    chk("w1_gap_ser", ser_out[0], 0);
    chk("w1_done", done[0], 1);
    chk("w1_gap_rdy", tx_ready[0], 0);
    @(negedge clk);
    chk("w1_rdy", tx_ready[0], 1);
    chk("w1_done_lo", done[0], 0);
    chk("w1_busy", busy[0], 0);

    // 3 cycles per bit.
    send(1, 4'b0110);
    frame(1, 4'b0110, 3, sh);
    chk("bc3_shifts", sh, 3);
    @(negedge clk);
    chk("bc3_frame_lo", ser_frame[1], 0);
    chk("bc3_done", done[1], 1);
    @(negedge clk);
    chk("bc3_rdy", tx_ready[1], 1);

    // No gap: done on the last frame cycle.
    send(2, 4'b1100);
    frame(2, 4'b1100, 1, sh);
    chk("g0_shifts", sh, 3);
    chk("g0_done", done[2], 1);
    @(negedge clk);
    chk("g0_rdy", tx_ready[2], 1);
    chk("g0_done_lo", done[2], 0);
    chk("g0_busy", busy[2], 0);

    // tx_valid held high: second accept spacing and no capture while busy.
    t = 0; t1 = -1; t2 = -1;
    tx_data[0]  = 4'b1010;
    tx_valid[0] = 1'b1;
    while (t < 40 && t2 < 0) begin
      @(negedge clk);
      t++;
      if (piso_load[0]) begin
        if (t1 < 0) begin
          t1 = t;
          chk("b2b_d1", piso_d[0], 4'b1010);
          tx_data[0] = 4'b0101;
        end else begin
          t2 = t;
          chk("b2b_d2", piso_d[0], 4'b0101);
        end
      end else if (busy[0] && t1 >= 0) begin
        chk("b2b_hold", piso_d[0], 4'b1010);
      end
    end
    tx_valid[0] = 1'b0;
    chk("b2b_seen", (t1 >= 0 && t2 >= 0) ? 1 : 0, 1);
    chk("b2b_spacing", t2 - t1, 7 + PB);
    t = 0;
    while (t < 30 && !tx_ready[0]) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_idle", tx_ready[0], 1);

    // Reset pulse mid-SHIFT aborts immediately with no done.
    send(0, 4'b1010);
    @(negedge clk);
    chk("mid_in_shift", ser_frame[0], 1);
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst", 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_done", done[0], 0);
      chk("mid_ready", tx_ready[0], 1);
      chk("mid_frame", ser_frame[0], 0);
    end

`ifdef PISO_TX_PARITY_EN
    // Parity bit of 1011 is 1 (odd count of ones).
    send(0, 4'b1011);
    frame(0, 4'b1011, 1, sh);
    chk("par_bit", ser_out[0], 1);
    chk("par_shifts", sh, 3);
    @(negedge clk);
    chk("par_frame_end", ser_frame[0], 0);
    chk("par_done", done[0], 1);
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
